// File: rtl/gf_inv_seq.sv
// GF(2^8) multiplicative inverse (AES polynomial) via a^254 square-and-multiply, one shared multiply per clock.
// 13-cycle latency from accept to done; start is ignored while busy (ready=0).
module gf_inv_seq #(
  parameter logic [7:0] POLY = 8'h1B
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] a_in,
  output logic       ready,
  output logic       done,
  output logic [7:0] inv_out
);

  typedef enum logic [1:0] {IDLE, SQR, MUL, FIN} state_t;

  state_t      state_q, state_d;
  logic [7:0]  op_q, op_d;
  logic [7:0]  r_q, r_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [7:0]  inv_q, inv_d;
  logic        done_q, done_d;
  logic [7:0]  mul_b;
  logic [7:0]  prod;

  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] acc;
    logic [7:0] m;
    acc = 8'h00;
    m   = x;
    for (int i = 0; i < 8; i++) begin
      if (y[i]) acc = acc ^ m;
      m = m[7] ? ({m[6:0], 1'b0} ^ POLY) : {m[6:0], 1'b0};
    end
    return acc;
  endfunction

  // Only MUL uses the latched operand; SQR and FIN both square the accumulator.
  assign mul_b = (state_q == MUL) ? op_q : r_q;
  assign prod  = gf_mul(r_q, mul_b);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    inv_d   = inv_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          op_d    = a_in;
          r_d     = a_in;
          cnt_d   = 3'd0;
          state_d = SQR;
        end
      end
      SQR: begin
        r_d     = prod;
        state_d = MUL;
      end
      MUL: begin
        r_d     = prod;
        cnt_d   = cnt_q + 3'd1;
        state_d = (cnt_q == 3'd5) ? FIN : SQR;
      end
      FIN: begin
        inv_d   = prod;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= 8'h00;
      r_q     <= 8'h00;
      cnt_q   <= 3'd0;
      inv_q   <= 8'h00;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      inv_q   <= inv_d;
      done_q  <= done_d;
    end
  end

  assign ready   = (state_q == IDLE);
  assign done    = done_q;
  assign inv_out = inv_q;

endmodule

// File: doc/gf_inv_seq.md
# gf_inv_seq

Sequential multiplicative-inverse unit over GF(2^8) with the AES reduction polynomial x^8+x^4+x^3+x+1. It computes a^-1 = a^254 by square-and-multiply, reusing one combinational GF(2^8) multiply per clock. It is the inverse-direction companion to the team's GF(2^8) multiplier and feeds the S-box / inverse S-box affine stages where area matters more than throughput. A start/ready/done handshake drives the computation, which takes 13 cycles of latency.

## Interface
- POLY, 8'h1B, low byte of the reduction polynomial, XORed in when a shifted bit overflows bit 7.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when ready=1.
- a_in  input  8  operand; captured on the accepting edge.
- ready  output  1  high when idle and able to accept start.
- done  output  1  one-cycle pulse; inv_out is valid from this cycle onward.
- inv_out  output  8  result; holds its value until the next done.

## Operation
- Registers:
  - op (latched operand).
  - r (accumulator).
  - cnt (3-bit iteration count).
  - state.
  - inv_out.
  - done.
- GF multiply rule: shift-and-add over 8 bits, LSB of the multiplier first.
  - Add = XOR.
  - After each shift of the multiplicand, XOR POLY if the pre-shift bit 7 was 1.
  - All values are 8 bits wide; no intermediate result wider than 8 bits is kept.
- States: IDLE, SQR, MUL, FIN.
  - IDLE: ready=1. When start=1: op<=a_in, r<=a_in, cnt<=0, go to SQR. When start=0, stay in IDLE.
  - SQR: r<=r·r, go to MUL.
  - MUL: r<=r·op, cnt<=cnt+1. If cnt==5 (this is the 6th MUL), go to FIN; otherwise go to SQR.
  - FIN: inv_out<=r·r, done<=1, go to IDLE.
- Exponent progression of r after each MUL: a^3, a^7, a^15, a^31, a^63, a^127. FIN yields a^254.
- a_in=0 gives inv_out=0 naturally (0^254=0). No special case is needed.
- start while ready=0 is ignored; a_in changes while busy have no effect.
- done is forced to 0 in every cycle except the one following the FIN edge.

## Timing
- Reset values (on the first edge with rst=1):
  - state=IDLE.
  - ready=1.
  - done=0.
  - inv_out=8'h00.
  - r, op, and cnt = 0.
- Reset has priority over everything, including mid-computation. The in-flight result is discarded, no done is produced, and inv_out reads 8'h00.
- ready is combinational from state (state==IDLE). It goes low the cycle after start is accepted.
- Latency, with start accepted at edge E0:
  - 6 SQR + 6 MUL + 1 FIN = 13 busy cycles.
  - The edge E13 registers inv_out and done=1, and state returns to IDLE.
  - In the cycle after E13: done=1 and ready=1 together.
- Back-to-back: start asserted in the done cycle is accepted at E14. The new inv_out appears at E27. Peak throughput is one inverse per 14 cycles.
- inv_out is stable between done pulses, including while the next computation runs.

## Test plan
- Known values: apply each input with a single-cycle start and check the result appears with done exactly 13 edges after acceptance.
  - a_in=0x53 -> 0xCA.
  - 0xCA -> 0x53.
  - 0x02 -> 0x8D.
  - 0x01 -> 0x01.
- Zero: a_in=0x00 -> inv_out=0x00 with done after 13 cycles; ready stays low throughout.
- Exhaustive: all 256 inputs, run back-to-back with start held high. For every nonzero a, check that the reference product a·inv_out equals 0x01. Check exactly 256 done pulses and 14 cycles between accepts.
- Busy protection: accept 0x53, then pulse start with a_in=0x02 at busy cycle 5. The result must be 0xCA, with only one done and no second computation.
- Reset mid-operation: accept 0x53, assert rst at busy cycle 7 for one cycle.
  - The next cycle shows ready=1, done=0, inv_out=0x00.
  - No done occurs afterward.
  - A subsequent start with 0x02 yields 0x8D.
- Hold: after done for 0x53, start 0x02. inv_out must read 0xCA throughout the next 13 busy cycles, then change to 0x8D with done.
